// File: rtl/uart_echo_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_echo_fifo_pkg
//  Description : Shared definitions for the UART echo block.
//                - parity-mode constants
//                - RX/TX state encodings
//                - clog2 and parity helper functions
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_echo_fifo_pkg;

    // Parity modes
    localparam int c_PAR_NONE = 0;
    localparam int c_PAR_EVEN = 1;
    localparam int c_PAR_ODD  = 2;

    typedef logic [2:0] rx_state_t;
    typedef logic [2:0] tx_state_t;

    // Receiver states
    localparam logic [2:0] c_RX_IDLE      = 3'd0;
    localparam logic [2:0] c_RX_START     = 3'd1;
    localparam logic [2:0] c_RX_DATA      = 3'd2;
    localparam logic [2:0] c_RX_PARITY    = 3'd3;
    localparam logic [2:0] c_RX_STOP      = 3'd4;
    localparam logic [2:0] c_RX_WAIT_IDLE = 3'd5;

    // Transmitter states
    localparam logic [2:0] c_TX_IDLE   = 3'd0;
    localparam logic [2:0] c_TX_START  = 3'd1;
    localparam logic [2:0] c_TX_DATA   = 3'd2;
    localparam logic [2:0] c_TX_PARITY = 3'd3;
    localparam logic [2:0] c_TX_STOP   = 3'd4;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Parity bit that makes the frame satisfy the requested mode. Narrow
    // characters are zero-extended, which does not change the XOR.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        if (mode == c_PAR_ODD) begin
            return ~(^data);
        end
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with first-word-fall-through read data.
//                A write to a full FIFO is dropped and flagged via
//                o_overflow, unless a pop happens in the same cycle.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_wr_en/i_wr_data - write request and data
//                i_rd_en          - pop request (ignored when empty)
//                o_rd_data        - current head entry
//                o_count          - occupancy
//                o_empty          - FIFO empty
//                o_overflow       - 1-cycle pulse on a dropped write
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import uart_echo_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wr_en,
    input  logic [WIDTH-1:0]        i_wr_data,
    input  logic                    i_rd_en,
    output logic [WIDTH-1:0]        o_rd_data,
    output logic [clog2(DEPTH):0]   o_count,
    output logic                    o_empty,
    output logic                    o_overflow
);

    localparam int              c_AW   = clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = DEPTH[c_AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_count;

    logic w_full;
    logic w_do_rd;
    logic w_do_wr;

    assign w_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign w_do_rd = i_rd_en && !o_empty;
    // A pop in the same cycle frees the slot, so a write to a full FIFO
    // is still accepted then.
    assign w_do_wr = i_wr_en && (!w_full || w_do_rd);

    assign o_rd_data  = r_mem[r_rptr];
    assign o_count    = r_count;
    assign o_overflow = i_wr_en && w_full && !w_do_rd;

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    // Power-of-two depth: pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_echo_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_echo_fifo
//  Description : UART receiver feeding a FIFO that drains into a UART
//                transmitter, so accepted characters are echoed back.
//  Ports       : clkIN        - clock, all logic on rising edge
//                resetIN      - synchronous active-high reset
//                rxIN         - asynchronous serial input, idle high
//                echoEnIN     - 1 lets the FIFO drain to TX
//                clearIN      - pulse, clears sticky error flags
//                txOUT        - serial output, idle high
//                rxDataOUT    - last accepted character
//                rxValidOUT   - 1-cycle pulse per accepted character
//                fifoCountOUT - FIFO occupancy
//                overflowOUT, parityErrOUT, frameErrOUT - sticky errors
//                nBusyOUT     - 1 while TX is idle
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_echo_fifo
    import uart_echo_fifo_pkg::*;
#(
    parameter int CLK_FREQ   = 5_760_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clkIN,
    input  logic                         resetIN,
    input  logic                         rxIN,
    input  logic                         echoEnIN,
    input  logic                         clearIN,
    output logic                         txOUT,
    output logic [DATA_BITS-1:0]         rxDataOUT,
    output logic                         rxValidOUT,
    output logic [clog2(FIFO_DEPTH):0]   fifoCountOUT,
    output logic                         overflowOUT,
    output logic                         parityErrOUT,
    output logic                         frameErrOUT,
    output logic                         nBusyOUT
);

    localparam int               c_CPB        = CLK_FREQ / BAUD_RATE;
    localparam int               c_CW         = clog2(c_CPB) + 1;
    localparam int               c_CPB_M1     = c_CPB - 1;
    localparam int               c_HALF_M1    = (c_CPB / 2) - 1;
    localparam int               c_DB_M1      = DATA_BITS - 1;
    localparam int               c_SB_M1      = STOP_BITS - 1;
    localparam logic [c_CW-1:0]  c_BAUD_LAST  = c_CPB_M1[c_CW-1:0];
    localparam logic [c_CW-1:0]  c_HALF_LAST  = c_HALF_M1[c_CW-1:0];
    localparam logic [3:0]       c_DATA_LAST  = c_DB_M1[3:0];
    localparam logic [3:0]       c_STOP_LAST  = c_SB_M1[3:0];

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic                  r_rx_meta;
    logic                  r_rx_sync;
    logic                  r_rx_prev;
    rx_state_t             r_rx_state;
    logic [c_CW-1:0]       r_rx_baud;
    logic [3:0]            r_rx_idx;
    logic [DATA_BITS-1:0]  r_rx_shift;
    logic                  r_rx_par_bad;
    logic                  r_rx_valid;
    logic [DATA_BITS-1:0]  r_rx_data;
    logic                  r_par_err;
    logic                  r_frame_err;

    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= c_RX_IDLE;
            r_rx_baud    <= '0;
            r_rx_idx     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_bad <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_rx_data    <= '0;
            r_par_err    <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_meta  <= rxIN;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_valid <= 1'b0;
            // Clear first; a set later in this block wins, so an error in
            // the same cycle as clearIN still reads back as 1.
            r_par_err   <= r_par_err & ~clearIN;
            r_frame_err <= r_frame_err & ~clearIN;

            case (r_rx_state)
                c_RX_IDLE: begin
                    r_rx_baud <= '0;
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= c_RX_START;
                    end
                end

                // Mid-start-bit check rejects short glitches silently.
                c_RX_START: begin
                    if (r_rx_baud == c_HALF_LAST) begin
                        r_rx_baud    <= '0;
                        r_rx_idx     <= '0;
                        r_rx_par_bad <= 1'b0;
                        r_rx_state   <= r_rx_sync ? c_RX_IDLE : c_RX_DATA;
                    end else begin
                        r_rx_baud <= r_rx_baud + 1'b1;
                    end
                end

                c_RX_DATA: begin
                    if (r_rx_baud == c_BAUD_LAST) begin
                        r_rx_baud  <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_idx == c_DATA_LAST) begin
                            r_rx_idx   <= '0;
                            r_rx_state <= (PARITY != c_PAR_NONE) ? c_RX_PARITY : c_RX_STOP;
                        end else begin
                            r_rx_idx <= r_rx_idx + 1'b1;
                        end
                    end else begin
                        r_rx_baud <= r_rx_baud + 1'b1;
                    end
                end

                // A bad parity is remembered and the frame still runs to
                // its stop bits so the line is resynchronised normally.
                c_RX_PARITY: begin
                    if (r_rx_baud == c_BAUD_LAST) begin
                        r_rx_baud  <= '0;
                        r_rx_idx   <= '0;
                        r_rx_state <= c_RX_STOP;
                        if (r_rx_sync != parity_bit(8'(r_rx_shift), PARITY)) begin
                            r_rx_par_bad <= 1'b1;
                            r_par_err    <= 1'b1;
                        end
                    end else begin
                        r_rx_baud <= r_rx_baud + 1'b1;
                    end
                end

                c_RX_STOP: begin
                    if (r_rx_baud == c_BAUD_LAST) begin
                        r_rx_baud <= '0;
                        if (!r_rx_sync) begin
                            r_frame_err <= 1'b1;
                            r_rx_state  <= c_RX_WAIT_IDLE;
                        end else if (r_rx_idx == c_STOP_LAST) begin
                            r_rx_state <= c_RX_IDLE;
                            if (!r_rx_par_bad) begin
                                r_rx_valid <= 1'b1;
                                r_rx_data  <= r_rx_shift;
                            end
                        end else begin
                            r_rx_idx <= r_rx_idx + 1'b1;
                        end
                    end else begin
                        r_rx_baud <= r_rx_baud + 1'b1;
                    end
                end

                c_RX_WAIT_IDLE: begin
                    r_rx_baud <= '0;
                    if (r_rx_sync) begin
                        r_rx_state <= c_RX_IDLE;
                    end
                end

                default: begin
                    r_rx_state <= c_RX_IDLE;
                    r_rx_baud  <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0]         w_fifo_head;
    logic [clog2(FIFO_DEPTH):0]   w_fifo_count;
    logic                         w_fifo_empty;
    logic                         w_fifo_ovf;
    logic                         w_pop;
    logic                         r_overflow;

    // The registered valid pulse doubles as the write strobe, so the write
    // lands in the same cycle rxValidOUT is high.
    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clkIN),
        .rst        (resetIN),
        .i_wr_en    (r_rx_valid),
        .i_wr_data  (r_rx_data),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_fifo_head),
        .o_count    (w_fifo_count),
        .o_empty    (w_fifo_empty),
        .o_overflow (w_fifo_ovf)
    );

    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= (r_overflow & ~clearIN) | w_fifo_ovf;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t             r_tx_state;
    logic [c_CW-1:0]       r_tx_baud;
    logic [3:0]            r_tx_idx;
    logic [DATA_BITS-1:0]  r_tx_shift;
    logic                  r_tx_par;
    logic                  r_tx;

    // echoEnIN is only consulted here, so dropping it never cuts a
    // character short.
    assign w_pop = (r_tx_state == c_TX_IDLE) && echoEnIN && !w_fifo_empty;

    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            r_tx_state <= c_TX_IDLE;
            r_tx_baud  <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                c_TX_IDLE: begin
                    r_tx_baud <= '0;
                    r_tx_idx  <= '0;
                    if (w_pop) begin
                        r_tx_shift <= w_fifo_head;
                        r_tx_par   <= parity_bit(8'(w_fifo_head), PARITY);
                        r_tx       <= 1'b0;
                        r_tx_state <= c_TX_START;
                    end
                end

                c_TX_START: begin
                    if (r_tx_baud == c_BAUD_LAST) begin
                        r_tx_baud  <= '0;
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_idx   <= '0;
                        r_tx_state <= c_TX_DATA;
                    end else begin
                        r_tx_baud <= r_tx_baud + 1'b1;
                    end
                end

                c_TX_DATA: begin
                    if (r_tx_baud == c_BAUD_LAST) begin
                        r_tx_baud <= '0;
                        if (r_tx_idx == c_DATA_LAST) begin
                            r_tx_idx <= '0;
                            if (PARITY != c_PAR_NONE) begin
                                r_tx       <= r_tx_par;
                                r_tx_state <= c_TX_PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_tx_state <= c_TX_STOP;
                            end
                        end else begin
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_idx   <= r_tx_idx + 1'b1;
                        end
                    end else begin
                        r_tx_baud <= r_tx_baud + 1'b1;
                    end
                end

                c_TX_PARITY: begin
                    if (r_tx_baud == c_BAUD_LAST) begin
                        r_tx_baud  <= '0;
                        r_tx_idx   <= '0;
                        r_tx       <= 1'b1;
                        r_tx_state <= c_TX_STOP;
                    end else begin
                        r_tx_baud <= r_tx_baud + 1'b1;
                    end
                end

                c_TX_STOP: begin
                    if (r_tx_baud == c_BAUD_LAST) begin
                        r_tx_baud <= '0;
                        if (r_tx_idx == c_STOP_LAST) begin
                            r_tx_state <= c_TX_IDLE;
                        end else begin
                            r_tx_idx <= r_tx_idx + 1'b1;
                        end
                    end else begin
                        r_tx_baud <= r_tx_baud + 1'b1;
                    end
                end

                default: begin
                    r_tx_state <= c_TX_IDLE;
                    r_tx       <= 1'b1;
                end
            endcase
        end
    end

    assign txOUT        = r_tx;
    assign rxDataOUT    = r_rx_data;
    assign rxValidOUT   = r_rx_valid;
    assign fifoCountOUT = w_fifo_count;
    assign overflowOUT  = r_overflow;
    assign parityErrOUT = r_par_err;
    assign frameErrOUT  = r_frame_err;
    assign nBusyOUT     = (r_tx_state == c_TX_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_echo_fifo.md
UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 5_760_000, meaning clkIN frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 9600, meaning line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide).
REQ-003 The block SHALL have parameter DATA_BITS, default 8, meaning character width; legal range 5..8.
REQ-004 The block SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, meaning stop-bit count; legal values 1 or 2.
REQ-006 The block SHALL have parameter FIFO_DEPTH, default 16, meaning FIFO entries; must be a power of 2, at least 2.
REQ-007 Port list (name, direction, width, meaning):
- clkIN  in  1  single clock; all logic on its rising edge.
- resetIN  in  1  synchronous, active-high reset.
- rxIN  in  1  asynchronous serial input, idle high.
- echoEnIN  in  1  1 = FIFO drains to TX; 0 = FIFO holds.
- clearIN  in  1  1-cycle pulse; clears sticky error flags.
- txOUT  out  1  serial output, idle high.
- rxDataOUT  out  DATA_BITS  last accepted character.
- rxValidOUT  out  1  1-cycle pulse per accepted character.
- fifoCountOUT  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflowOUT, parityErrOUT, frameErrOUT  out  1 each  sticky error flags.
- nBusyOUT  out  1  1 when TX is IDLE.

Function
REQ-008 rxIN SHALL pass through a 2-flop synchronizer before any use.
REQ-009 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE->START on synchronized falling edge.
- START samples at CLKS_PER_BIT/2: low -> DATA; high -> IDLE (glitch, no flag).
REQ-010 DATA SHALL sample DATA_BITS bits LSB first, each one CLKS_PER_BIT after the previous.
- Exits to PARITY if PARITY!=0, otherwise to STOP.
REQ-011 PARITY SHALL sample one bit; mismatch against even/odd parity of the data SHALL discard the character and set parityErrOUT.
REQ-012 STOP SHALL sample STOP_BITS bits.
- Any zero SHALL discard the character, set frameErrOUT and go to WAIT_IDLE.
- WAIT_IDLE returns to IDLE only when the synchronized line is high.
REQ-013 An accepted character SHALL update rxDataOUT, pulse rxValidOUT and write the FIFO, all in the cycle after the final stop-bit sample.
REQ-014 A write to a full FIFO SHALL drop the character, set overflowOUT and leave the FIFO unchanged.
- rxValidOUT still pulses and rxDataOUT still updates.
REQ-015 A write and a pop in the same cycle SHALL both take effect; fifoCountOUT is unchanged and no overflow occurs, even when full.
- Read/write pointers wrap modulo FIFO_DEPTH.
REQ-016 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- IDLE pops the FIFO head when echoEnIN=1 and the FIFO is not empty.
- txOUT goes low on the next cycle and holds each bit for exactly CLKS_PER_BIT cycles.
- Bit order: start, DATA_BITS LSB first, optional parity, STOP_BITS high bits.
REQ-017 Worst-case latency from rxValidOUT to the txOUT falling edge SHALL be 3 cycles when TX is idle and echoEnIN=1.
REQ-018 Deasserting echoEnIN mid-character SHALL NOT abort the character being sent; it only blocks the next pop.
REQ-019 nBusyOUT SHALL be 1 only in TX IDLE.
REQ-020 clearIN SHALL clear all three sticky flags.
- If a new error occurs in the same cycle as clearIN, that flag SHALL read 1.

Reset
REQ-021 While resetIN=1 at a clock edge, the block SHALL force:
- both FSMs to IDLE and all bit/baud counters to 0;
- FIFO empty (fifoCountOUT=0);
- txOUT=1, nBusyOUT=1, rxValidOUT=0, rxDataOUT=0, all error flags 0;
- synchronizer flops to 1.
REQ-022 Reset during an active RX or TX character SHALL abandon it.
- No partial FIFO write occurs.
- txOUT is high in the cycle after the reset edge.

Structure
REQ-023 A shared package SHALL hold the parity-mode constants, the RX/TX state enums and a clog2 function.
REQ-024 The FIFO SHALL be one sub-module, sync_fifo (parameters WIDTH, DEPTH), instanced once.
- RX and TX FSMs stay in the top module.

Verification (CLK_FREQ=5_760_000, BAUD_RATE=9600, so 600 clocks/bit)
REQ-025 With defaults, echoEnIN=1, send 0x55 -> rxValidOUT pulse with rxDataOUT=0x55; txOUT falls within 3 cycles and emits 0x55 over 6000 cycles.
REQ-026 With PARITY=1, send 0xA3 with a wrong parity bit -> parityErrOUT=1, no rxValidOUT, fifoCountOUT stays 0; clearIN -> flag 0.
REQ-027 Send 0x41 with a stop bit of 0 -> frameErrOUT=1, no FIFO write; a following 0x42 is received correctly after the line returns high.
REQ-028 With echoEnIN=0 and FIFO_DEPTH=4, send 5 characters -> fifoCountOUT=4, overflowOUT=1; set echoEnIN=1 -> the first 4 characters are echoed in order.
REQ-029 A 300-cycle low glitch on rxIN -> no state change beyond START, no flags set.
REQ-030 Assert resetIN mid-TX (after bit 3) -> txOUT=1 the next cycle, fifoCountOUT=0, nBusyOUT=1.
